// File: rtl/efuse_pkg.sv
// Shared encodings for the user eFuse programmer: FSM states, PROG_ERR status
// codes and the pulse/settle counter width.
package efuse_pkg;

   localparam int FUSE_W = 32;
   localparam int IDX_W  = 5;
   localparam int CNT_W  = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SCAN   = 3'd1;
   localparam logic [2:0] ST_BURN   = 3'd2;
   localparam logic [2:0] ST_SETTLE = 3'd3;
   localparam logic [2:0] ST_VERIFY = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_DISABLED = 2'b01;
   localparam logic [1:0] ERR_CLEAR    = 2'b10;

   // A bit already blown but absent from the target can never be cleared (OTP).
   function automatic logic clear_attempt(input logic [FUSE_W-1:0] target,
                                          input logic [FUSE_W-1:0] fuse);
      return |(~target & fuse);
   endfunction

endpackage

// File: rtl/efuse_pulse_timer.sv
// Down-counter that times the burn pulse and the post-burn settle window.
// expire_o is high while the count sits at zero.
module efuse_pulse_timer
   import efuse_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] count_o,
   output logic             expire_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o  = count_q;
   assign expire_o = (count_q == '0);

endmodule

// File: rtl/efuse_usr_prog.sv
// User eFuse programming controller: scans the 32-bit target, burns each bit that
// is requested but not yet blown, then verifies and reports a status code.
module efuse_usr_prog
   import efuse_pkg::*;
#(
   parameter logic [31:0] SIM_EFUSE_VALUE   = 32'h00000000,
   parameter int unsigned PROG_PULSE_CYCLES = 16,
   parameter int unsigned SETTLE_CYCLES     = 4
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        PROG_EN,
   input  logic        PROG_START,
   input  logic [31:0] PROG_DATA,
   output logic        PROG_BUSY,
   output logic        PROG_DONE,
   output logic [1:0]  PROG_ERR,
   output logic        FUSE_BURN_EN,
   output logic [4:0]  FUSE_BIT_IDX,
   output logic [31:0] EFUSEUSR
);

   // The timer counts down to zero inclusive, so it is loaded with length-1.
   localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PROG_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FUSE_W - 1);

   logic [2:0]        state_q, state_d;
   logic [FUSE_W-1:0] tgt_q, tgt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [1:0]        err_q, err_d;
   // Non-volatile array: loaded once at time zero and untouched by reset.
   logic [FUSE_W-1:0] fuse_q = SIM_EFUSE_VALUE;
   logic [FUSE_W-1:0] fuse_d;

   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_load_val;
   logic [CNT_W-1:0]  unused_tmr_count;
   logic              tmr_expire;
   logic              need_burn;

   efuse_pulse_timer u_timer (
      .clk_i      (CLK),
      .rst_ni     (RST_N),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .count_o    (unused_tmr_count),
      .expire_o   (tmr_expire)
   );

   always_comb begin
      state_d      = state_q;
      tgt_d        = tgt_q;
      idx_d        = idx_q;
      err_d        = err_q;
      fuse_d       = fuse_q;
      tmr_load     = 1'b0;
      tmr_load_val = PULSE_LOAD;
      need_burn    = tgt_q[idx_q] & ~fuse_q[idx_q];

      case (state_q)
         ST_IDLE: begin
            if (PROG_START) begin
               tgt_d = PROG_DATA;
               idx_d = '0;
               err_d = ERR_OK;
               if (!PROG_EN) begin
                  err_d   = ERR_DISABLED;
                  state_d = ST_DONE;
               end else begin
                  if (clear_attempt(PROG_DATA, fuse_q)) begin
                     err_d = ERR_CLEAR;
                  end
                  state_d = ST_SCAN;
               end
            end
         end
         ST_SCAN: begin
            if (need_burn) begin
               tmr_load     = 1'b1;
               tmr_load_val = PULSE_LOAD;
               state_d      = ST_BURN;
            end else if (idx_q == LAST_IDX) begin
               state_d = ST_VERIFY;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_BURN: begin
            // The bit only counts as blown once the full pulse has been applied.
            if (tmr_expire) begin
               fuse_d       = fuse_q | (FUSE_W'(1) << idx_q);
               tmr_load     = 1'b1;
               tmr_load_val = SETTLE_LOAD;
               state_d      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (tmr_expire) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_VERIFY;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_SCAN;
               end
            end
         end
         ST_VERIFY: begin
            if ((fuse_q & tgt_q) != tgt_q) begin
               err_d = ERR_CLEAR;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         tgt_q   <= '0;
         idx_q   <= '0;
         err_q   <= ERR_OK;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge CLK) begin
      fuse_q <= fuse_d;
   end

   assign PROG_BUSY    = (state_q == ST_SCAN) || (state_q == ST_BURN) ||
                         (state_q == ST_SETTLE) || (state_q == ST_VERIFY);
   assign PROG_DONE    = (state_q == ST_DONE);
   assign PROG_ERR     = err_q;
   assign FUSE_BURN_EN = (state_q == ST_BURN);
   assign FUSE_BIT_IDX = ((state_q == ST_SCAN) || (state_q == ST_BURN) ||
                          (state_q == ST_SETTLE)) ? idx_q : '0;
   assign EFUSEUSR     = fuse_q;

endmodule

// File: tb/tb_efuse_usr_prog.sv
// Scoreboard bench for efuse_usr_prog: dut0 starts blank, dut1 starts with 0xF0
// pre-blown, dut2 starts blank and is used for the reset-during-burn case.
module tb_efuse_usr_prog;

   localparam int NDUT = 3;

   typedef struct {
      int          id;
      int          lat;
      logic [1:0]  err;
      logic [31:0] fuse;
   } exp_t;

   typedef struct {
      int id;
      int idx;
   } bexp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [NDUT];
   logic        en    [NDUT];
   logic        st    [NDUT];
   logic [31:0] dat   [NDUT];
   logic        busy  [NDUT];
   logic        done  [NDUT];
   logic [1:0]  err   [NDUT];
   logic        burn  [NDUT];
   logic [4:0]  idx   [NDUT];
   logic [31:0] fuse  [NDUT];

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      efuse_usr_prog #(
         .SIM_EFUSE_VALUE   ((g == 1) ? 32'h000000F0 : 32'h00000000),
         .PROG_PULSE_CYCLES (16),
         .SETTLE_CYCLES     (4)
      ) u_dut (
         .CLK          (clk),
         .RST_N        (rst_n[g]),
         .PROG_EN      (en[g]),
         .PROG_START   (st[g]),
         .PROG_DATA    (dat[g]),
         .PROG_BUSY    (busy[g]),
         .PROG_DONE    (done[g]),
         .PROG_ERR     (err[g]),
         .FUSE_BURN_EN (burn[g]),
         .FUSE_BIT_IDX (idx[g]),
         .EFUSEUSR     (fuse[g])
      );
   end

   int          total = 0;
   int          bad   = 0;
   int          edges = 0;
   exp_t        sb_q [$];
   bexp_t       bq [$];
   logic [31:0] fm     [NDUT];
   int          t0     [NDUT];
   bit          act    [NDUT];
   int          bw     [NDUT];
   int          bidx   [NDUT];
   bit          babort [NDUT];

   always @(posedge clk) edges <= edges + 1;

   task automatic chk(input string nm, input int id, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s dut%0d: got %0h expected %0h", nm, id, a, e);
      end
   endtask

   // Monitor: pops the scoreboard on every PROG_DONE and checks every burn pulse.
   always @(negedge clk) begin
      exp_t  e;
      bexp_t b;
      for (int i = 0; i < NDUT; i++) begin
         if (done[i]) begin
            if (sb_q.size() == 0 || sb_q[0].id != i) begin
               total++;
               bad++;
               $display("FAIL unexpected_done dut%0d", i);
            end else begin
               e = sb_q.pop_front();
               chk("done_latency", i, edges - t0[i] + 1, e.lat);
               chk("prog_err", i, 32'(err[i]), 32'(e.err));
               chk("efuseusr", i, fuse[i], e.fuse);
               chk("busy_in_done", i, 32'(busy[i]), 0);
            end
            act[i] = 1'b0;
         end else if (act[i]) begin
            chk("busy", i, 32'(busy[i]), 1);
         end

         if (burn[i]) begin
            if (bw[i] == 0) bidx[i] = int'(idx[i]);
            bw[i]++;
         end else if (bw[i] > 0) begin
            if (bq.size() == 0 || bq[0].id != i) begin
               total++;
               bad++;
               $display("FAIL unexpected_burn dut%0d idx=%0d width=%0d", i, bidx[i], bw[i]);
            end else begin
               b = bq.pop_front();
               if (!babort[i]) begin
                  chk("burn_width", i, bw[i], 16);
                  chk("burn_idx", i, bidx[i], b.idx);
               end
            end
            babort[i] = 1'b0;
            bw[i]     = 0;
         end
      end
   end

   // Issues one start with hand-computed expected latency, status and array.
   task automatic start(input int id, input logic e_n, input logic [31:0] d,
                        input int lat, input logic [1:0] e_err, input logic [31:0] e_fuse);
      exp_t  x;
      bexp_t bx;
      @(negedge clk);
      if (e_n) begin
         for (int b = 0; b < 32; b++) begin
            if (d[b] && !fm[id][b]) begin
               bx.id  = id;
               bx.idx = b;
               bq.push_back(bx);
            end
         end
         fm[id] = e_fuse;
      end
      x.id   = id;
      x.lat  = lat;
      x.err  = e_err;
      x.fuse = e_fuse;
      sb_q.push_back(x);
      t0[id]  = edges + 1;
      en[id]  = e_n;
      dat[id] = d;
      st[id]  = 1'b1;
      @(posedge clk);
      act[id] = e_n;
      @(negedge clk);
      st[id] = 1'b0;
   endtask

   task automatic wait_done(input int id);
      int k;
      k = 0;
      while (!done[id] && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (!done[id]) begin
         total++;
         bad++;
         $display("FAIL done_timeout dut%0d: got no PROG_DONE expected one", id);
      end
   endtask

   task automatic chk_idle(input string nm, input int id, input logic [31:0] efuse);
      chk({nm, "_busy"}, id, 32'(busy[id]), 0);
      chk({nm, "_done"}, id, 32'(done[id]), 0);
      chk({nm, "_err"}, id, 32'(err[id]), 0);
      chk({nm, "_burn"}, id, 32'(burn[id]), 0);
      chk({nm, "_idx"}, id, 32'(idx[id]), 0);
      chk({nm, "_efuse"}, id, fuse[id], efuse);
   endtask

   initial begin
      int k;
      fm[0] = 32'h0;
      fm[1] = 32'h000000F0;
      fm[2] = 32'h0;
      for (int i = 0; i < NDUT; i++) begin
         rst_n[i] = 1'b0;
         en[i] = 1'b0;
         st[i] = 1'b0;
         dat[i] = 32'h0;
         act[i] = 1'b0;
         bw[i] = 0;
         bidx[i] = 0;
         babort[i] = 1'b0;
         t0[i] = 0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < NDUT; i++) chk_idle("reset", i, fm[i]);
      for (int i = 0; i < NDUT; i++) rst_n[i] = 1'b1;
      @(negedge clk);

      // Two bits burned from a blank array.
      start(0, 1'b1, 32'h00000005, 74, 2'b00, 32'h00000005);
      wait_done(0);
      // Same data again: nothing left to burn.
      start(0, 1'b1, 32'h00000005, 34, 2'b00, 32'h00000005);
      wait_done(0);
      // Programming disabled.
      start(0, 1'b0, 32'hFFFFFFFF, 1, 2'b01, 32'h00000005);
      wait_done(0);
      // Start re-issued while busy must be ignored.
      start(0, 1'b1, 32'h00000305, 74, 2'b00, 32'h00000305);
      repeat (10) @(negedge clk);
      dat[0] = 32'hFFFF0000;
      en[0]  = 1'b1;
      st[0]  = 1'b1;
      @(negedge clk);
      st[0]  = 1'b0;
      dat[0] = 32'h00000305;
      wait_done(0);
      // Target omits blown bits: informational clear-attempt, then cleared by next start.
      start(0, 1'b1, 32'h00000300, 34, 2'b10, 32'h00000305);
      wait_done(0);
      start(0, 1'b1, 32'h00000305, 34, 2'b00, 32'h00000305);
      wait_done(0);

      // Pre-blown array, low nibble requested.
      start(1, 1'b1, 32'h0000000F, 114, 2'b10, 32'h000000FF);
      wait_done(1);

      // Reset during the 8th cycle of the bit-31 burn pulse.
      begin
         bexp_t bx;
         bx.id  = 2;
         bx.idx = 31;
         bq.push_back(bx);
      end
      @(negedge clk);
      t0[2]  = edges + 1;
      dat[2] = 32'h80000000;
      en[2]  = 1'b1;
      st[2]  = 1'b1;
      @(posedge clk);
      act[2] = 1'b1;
      @(negedge clk);
      st[2] = 1'b0;
      k = 0;
      while (!burn[2] && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!burn[2]) begin
         total++;
         bad++;
         $display("FAIL burn_timeout dut2: got no FUSE_BURN_EN expected a pulse");
      end
      repeat (7) @(negedge clk);
      babort[2] = 1'b1;
      act[2]    = 1'b0;
      rst_n[2]  = 1'b0;
      @(negedge clk);
      chk_idle("abort", 2, 32'h00000000);
      rst_n[2] = 1'b1;
      start(2, 1'b1, 32'h80000000, 54, 2'b00, 32'h80000000);
      wait_done(2);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 0, sb_q.size(), 0);
      chk("burn_queue_empty", 0, bq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/efuse_usr_prog.md
EFUSE_USR_PROG -- requirements
Module: efuse_usr_prog

Interface
REQ-001 SHALL have parameter SIM_EFUSE_VALUE, default 32'h00000000: fuse array content at time zero.
REQ-002 SHALL have parameter PROG_PULSE_CYCLES, default 16: burn pulse width in CLK cycles, legal range 1..255.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4: post-burn recovery in CLK cycles, legal range 1..255.
REQ-004 SHALL have port CLK  input  1  the single clock; all state advances on the rising edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port PROG_EN  input  1  programming enable, sampled together with PROG_START.
REQ-007 SHALL have port PROG_START  input  1  one-cycle request to program PROG_DATA.
REQ-008 SHALL have port PROG_DATA  input  32  target bits; a 1 means burn the bit.
REQ-009 SHALL have port PROG_BUSY  output  1  high from the cycle after an accepted start until DONE.
REQ-010 SHALL have port PROG_DONE  output  1  one-cycle completion pulse.
REQ-011 SHALL have port PROG_ERR  output  2  status code: 00 ok, 01 disabled, 10 clear-attempt; held until the next accepted start.
REQ-012 SHALL have port FUSE_BURN_EN  output  1  high while a burn pulse is applied.
REQ-013 SHALL have port FUSE_BIT_IDX  output  5  index of the bit under scan or burn.
REQ-014 SHALL have port EFUSEUSR  output  32  current fuse array content, a combinational view of the array.

Function
REQ-015 SHALL use the states IDLE, SCAN, BURN, SETTLE, VERIFY and DONE.
REQ-016 SHALL accept PROG_START only in IDLE; a start in any other state is ignored with no side effect.
REQ-017 SHALL, on an accepted start, capture PROG_DATA into a target register, clear PROG_ERR, and set the index to 0.
REQ-018 SHALL, when PROG_EN=0 at the accepted start: go directly to DONE, set PROG_ERR=01, and leave the array untouched.
REQ-019 SHALL, when PROG_EN=1 and (target & ~fuse) != 0 is false for every bit, still perform the full scan of all 32 bits.
REQ-020 SHALL spend exactly 1 cycle per bit in SCAN.
REQ-021 SHALL, in SCAN, go to BURN if target[idx]=1 and fuse[idx]=0; otherwise increment the index.
REQ-022 SHALL, in BURN, hold FUSE_BURN_EN=1 for exactly PROG_PULSE_CYCLES cycles.
REQ-023 SHALL set fuse[idx] to 1 on the final BURN cycle edge, then enter SETTLE.
REQ-024 SHALL, in SETTLE, wait SETTLE_CYCLES cycles, then increment the index and return to SCAN.
REQ-025 SHALL go to VERIFY after index 31 completes; VERIFY takes 1 cycle and then goes to DONE.
REQ-026 SHALL set PROG_ERR=10 when target[i]=0 and fuse[i]=1 for any i at capture; the array is OTP, burning of the other bits proceeds, and the condition is informational.
REQ-027 SHALL, in VERIFY, set PROG_ERR=10 if (fuse & target) != target; unreachable in the model, retained for gate-level fault injection.
REQ-028 SHALL, in DONE, assert PROG_DONE for 1 cycle and return to IDLE; PROG_BUSY=0 in that cycle.
REQ-029 SHALL produce PROG_DONE exactly 34 + N*(PROG_PULSE_CYCLES+SETTLE_CYCLES) cycles after the start edge, where N = popcount(target & ~fuse); for the disabled case, exactly 1 cycle after.
REQ-030 SHALL never clear a fuse bit; the array bits are monotonic 0->1.
REQ-031 SHALL drive FUSE_BIT_IDX = index in SCAN, BURN and SETTLE, and 0 otherwise.
REQ-032 SHALL allow a new start to be accepted in the cycle after DONE.

Reset
REQ-033 SHALL, while RST_N=0, hold state=IDLE, PROG_BUSY=0, PROG_DONE=0, PROG_ERR=00, FUSE_BURN_EN=0, FUSE_BIT_IDX=0, and the target register, index and counters at 0.
REQ-034 SHALL never alter the fuse array on reset; the array is non-volatile and loads SIM_EFUSE_VALUE only at time zero.
REQ-035 SHALL, when reset is asserted mid-BURN, leave the bit being burned unset, since the pulse is incomplete; bits already burned remain set.

Structure
REQ-036 SHALL place the state enumeration, the PROG_ERR code constants and the counter width (8) in a shared package, efuse_pkg.
REQ-037 SHALL implement the pulse/settle cycle counter as a single sub-module, efuse_pulse_timer, with load, count and expire outputs.
REQ-038 SHALL be a single-level FSM plus datapath otherwise, with no other sub-modules.

Verification
REQ-039 SHALL cover: SIM_EFUSE_VALUE=0, PROG_EN=1, PROG_DATA=32'h00000005 -> EFUSEUSR=32'h00000005, two 16-cycle FUSE_BURN_EN pulses at idx 0 and 2, PROG_DONE at cycle 74, PROG_ERR=00.
REQ-040 SHALL cover: PROG_EN=0, PROG_DATA=32'hFFFFFFFF -> PROG_DONE at cycle 1, PROG_ERR=01, EFUSEUSR unchanged, FUSE_BURN_EN never high.
REQ-041 SHALL cover: SIM_EFUSE_VALUE=32'h000000F0, PROG_DATA=32'h0000000F -> PROG_ERR=10, EFUSEUSR=32'h000000FF, PROG_DONE at cycle 114.
REQ-042 SHALL cover: PROG_DATA=32'h80000000, with RST_N pulsed low at the 8th BURN cycle -> EFUSEUSR=0 and FSM in IDLE; a restarted program sets bit 31 with PROG_DONE at cycle 54.
REQ-043 SHALL cover: PROG_START re-asserted while busy with PROG_DATA=32'hFFFF0000 -> ignored, and the first target's result and timing are unchanged.
REQ-044 SHALL cover: a repeated program with identical data -> N=0, no burn pulses, PROG_DONE at cycle 34, PROG_ERR=00.
